mul_seq_param: RTL
==================

Name: mul_seq_param

Overview:
- Parametrised sequential shift-add multiplier; next generation of the team's 8x8 iterative multiplier.
- Generalised to WIDTH-bit operands, with a runtime signed/unsigned mode and a start/busy/done handshake.
- Product is held stable between operations.
- Sits beside the datapath as a multi-cycle arithmetic unit, driven by a controller that issues start and waits for done.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- areset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = operands are two's complement; sampled with start.
- A  input  WIDTH  multiplicand; sampled with start.
- B  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  result register.

Behaviour:
- Reset (areset_n low, asynchronous): state=IDLE, busy=0, done=0, product=0, counter=0, internal registers=0.
- Reset asserted mid-operation aborts the operation immediately; no done pulse; product=0.
- FSM states:
  - IDLE -> RUN when start=1 at a clock edge (E0).
  - RUN -> FIN when counter reaches WIDTH.
  - FIN -> IDLE unconditionally.
- E0 latch:
  - Unsigned: mag_a=A, mag_b=B.
  - Signed: mag_a=|A|, mag_b=|B| as WIDTH-bit unsigned (-2^(WIDTH-1) maps to 2^(WIDTH-1) with no overflow); neg = A[msb]^B[msb].
  - acc=0, counter=0, busy=1.
- RUN, each edge:
  - If mag_b[0]: acc += mag_a << counter (2*WIDTH-bit add, no overflow possible).
  - mag_b >>= 1; counter++.
  - Exactly WIDTH RUN edges (E1..EW).
- FIN, edge E(W+1):
  - product <= neg ? -acc : acc (2*WIDTH two's complement).
  - done=1 for this cycle only; busy=0.
- Latency: start edge to done visible = WIDTH+1 clocks; back-to-back start is accepted in the IDLE cycle after FIN.
- start while busy or in FIN: ignored; operands are not re-latched.
- A, B and signed_mode changing during RUN: no effect.
- product changes only at FIN; it holds the previous result throughout RUN.
- done and busy are never high together.

Optional Feature:
- Macro MUL_SEQ_EARLY_TERM_EN.
- Defined: in RUN, if the shifted mag_b == 0, go to FIN at the next edge (skip remaining bits).
  - Also checked at E0: B==0 goes RUN for one edge, then FIN.
  - Minimum latency 2 clocks.
  - Latency = (index of highest set bit of mag_b) + 2 clocks.
- Undefined: fixed WIDTH+1 latency for all operands.
- Result values are identical in both builds.

Decomposition:
- Shared package mul_pkg:
  - State enum/localparams IDLE=2'd0, RUN=2'd1, FIN=2'd2.
  - Function abs_w (WIDTH-bit two's-complement magnitude).
  - Default WIDTH constant.
- One natural sub-module, mul_seq_ctrl: FSM plus counter, outputs busy/done/load/step/finish strobes.
- Accumulator, shifter and sign fix-up stay in mul_seq_param.

Test Plan (WIDTH=8):
- Unsigned: start with A=255, B=100, signed_mode=0 -> done exactly 9 clocks after the start edge; product=16'd25500 (0x639C). busy high for 8 cycles.
- Unsigned: A=255, B=255 -> product=0xFE01. Then A=1, B=1 issued the cycle after done -> product=0x0001; product must hold 0xFE01 until the second done.
- Signed: signed_mode=1, A=-128 (0x80), B=-128 -> product=0x4000. Then A=-1 (0xFF), B=100 -> product=0xFF9C (-100).
- Handshake: start held high and A, B changed during RUN -> only the first operands are computed; exactly one done per accepted start.
- Reset mid-operation: areset_n low for 1 cycle at RUN cycle 4 -> busy=0, done=0, product=0 immediately (asynchronous). The next start computes normally.
- Early termination (MUL_SEQ_EARLY_TERM_EN):
  - A=5, B=1 -> done 2 clocks after start, product=5.
  - A=5, B=0 -> product=0 at 2 clocks.
  - A=3, B=0x80 -> product=0x0180 at 9 clocks.
  - Without the macro, all three take 9 clocks with the same products.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 8;
  // Widest operand abs_w can handle; callers sign-extend into this width.
  localparam int ABS_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Two's-complement magnitude. The most negative WIDTH-bit value maps to
  // 2^(WIDTH-1), which still fits once the caller truncates back to WIDTH bits.
  function automatic logic [ABS_MAX_W-1:0] abs_w(input logic signed [ABS_MAX_W-1:0] v);
    logic [ABS_MAX_W-1:0] u;
    u = v;
    return v[ABS_MAX_W-1] ? (~u + ABS_MAX_W'(1)) : u;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// Multiplier sequencer: IDLE/RUN/FIN FSM, bit counter and load/step/finish strobes.
// MUL_SEQ_EARLY_TERM_EN lets RUN end as soon as the remaining multiplier bits are zero.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start_i,
  input  logic             last_bit_i,
  output state_t           state_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o,
  output logic             load_o,
  output logic             step_o,
  output logic             finish_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= finish_o;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_o   = 1'b0;
    step_o   = 1'b0;
    finish_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step_o = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIN;
        end
`ifdef MUL_SEQ_EARLY_TERM_EN
        else if (last_bit_i) begin
          state_d = FIN;
        end
`endif
      end
      FIN: begin
        finish_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef MUL_SEQ_EARLY_TERM_EN
  logic unused_last_bit;
  assign unused_last_bit = last_bit_i;
`endif

  assign state_o = state_q;
  assign cnt_o   = cnt_q;
  assign done_o  = done_q;

endmodule

// File: rtl/mul_seq_param.sv
// WIDTH-bit sequential shift-add multiplier, signed/unsigned at runtime, start/busy/done.
// Optional MUL_SEQ_EARLY_TERM_EN (in mul_seq_ctrl) shortens latency for small multipliers.
module mul_seq_param
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               load, step, finish, last_bit;

  logic [WIDTH-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, product_q, product_d;
  logic               neg_q, neg_d;

  logic signed [ABS_MAX_W-1:0] a_ext, b_ext;
  logic [WIDTH-1:0]   lat_a, lat_b;
  logic [2*WIDTH-1:0] addend;

  mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
    .clk       (clk),
    .areset_n  (areset_n),
    .start_i   (start),
    .last_bit_i(last_bit),
    .state_o   (state),
    .cnt_o     (cnt),
    .done_o    (done),
    .load_o    (load),
    .step_o    (step),
    .finish_o  (finish)
  );

  assign a_ext    = ABS_MAX_W'($signed(A));
  assign b_ext    = ABS_MAX_W'($signed(B));
  assign lat_a    = signed_mode ? WIDTH'(abs_w(a_ext)) : A;
  assign lat_b    = signed_mode ? WIDTH'(abs_w(b_ext)) : B;
  assign addend   = {{WIDTH{1'b0}}, mag_a_q} << cnt;
  // True when no set bits remain after the one consumed on this step.
  assign last_bit = ((mag_b_q >> 1) == '0);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (load) begin
      mag_a_d = lat_a;
      mag_b_d = lat_b;
      acc_d   = '0;
      neg_d   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
    end
    if (step) begin
      if (mag_b_q[0]) acc_d = acc_q + addend;
      mag_b_d = mag_b_q >> 1;
    end
    if (finish) begin
      product_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    end
  end

  assign busy    = (state == RUN);
  assign product = product_q;

endmodule
